// File: rtl/snax_simbacore_pkg.sv
// Shared types and CSR word/status indices for the SimbaCore CSR controller.
package snax_simbacore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int unsigned CsrMode   = 0;
  localparam int unsigned CsrSeqLen = 1;
  localparam int unsigned CsrDModel = 2;
  localparam int unsigned CsrDtRank = 3;
  localparam int unsigned CsrDInner = 4;
  localparam int unsigned CsrDFinal = 5;
  localparam int unsigned CsrStart  = 6;

  localparam int unsigned RoBusy     = 0;
  localparam int unsigned RoCycles   = 1;
  localparam int unsigned RoLaunches = 2;
  localparam int unsigned RoMode     = 3;

endpackage

// File: rtl/snax_simbacore_sat_counter.sv
// Up-counter with synchronous clear; Saturate selects hold-at-all-ones vs wrap.
module snax_simbacore_sat_counter #(
  parameter int unsigned Width    = 32,
  parameter bit          Saturate = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      if (!(Saturate && (count_q == '1))) begin
        count_q <= count_q + {{(Width-1){1'b0}}, 1'b1};
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/snax_simbacore_csr_ctrl.sv
// CSR-to-SimbaCore launch controller: latches config words, issues io_config, tracks busy.
// Optional cycle counter on ro[1] enabled by SNAX_SIMBACORE_CSR_PERF_CNT_EN.
module snax_simbacore_csr_ctrl
  import snax_simbacore_pkg::*;
#(
  parameter int unsigned RegRWCount   = 7,
  parameter int unsigned RegROCount   = 4,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned ModeWidth    = 13
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [RegDataWidth-1:0] csr_reg_set_i [RegRWCount],
  input  logic                    csr_reg_set_valid_i,
  output logic                    csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0] csr_reg_ro_set_o [RegROCount],
  output logic                    cfg_valid_o,
  input  logic                    cfg_ready_i,
  output logic [ModeWidth-1:0]    cfg_mode_o,
  output logic [RegDataWidth-1:0] cfg_seq_len_o,
  output logic [RegDataWidth-1:0] cfg_d_model_o,
  output logic [RegDataWidth-1:0] cfg_dt_rank_o,
  output logic [RegDataWidth-1:0] cfg_d_inner_o,
  output logic [RegDataWidth-1:0] cfg_d_final_o,
  input  logic                    core_busy_i
);

  state_e state_q, state_d;
  logic   busy_seen_q, busy_seen_d;
  logic   accept, handshake;

  logic [ModeWidth-1:0]    mode_q;
  logic [RegDataWidth-1:0] seq_len_q, d_model_q, dt_rank_q, d_inner_q, d_final_q;
  logic [RegDataWidth-1:0] cycle_cnt, launch_cnt;

  // Start word and the bits of word 0 above the mode field carry no information here.
  logic unused_csr_bits;
  assign unused_csr_bits = ^{csr_reg_set_i[CsrStart],
                             csr_reg_set_i[CsrMode][RegDataWidth-1:ModeWidth]};

  assign csr_reg_set_ready_o = (state_q == IDLE);
  assign accept              = csr_reg_set_valid_i & csr_reg_set_ready_o;
  assign cfg_valid_o         = (state_q == ISSUE);
  assign handshake           = cfg_valid_o & cfg_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      busy_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_seen_d = busy_seen_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          busy_seen_d = 1'b0;
        end
      end
      ISSUE: begin
        if (cfg_ready_i) state_d = (mode_q == '0) ? IDLE : RUN;
      end
      RUN: begin
        // Completion needs a busy cycle strictly before the idle one.
        if (core_busy_i)      busy_seen_d = 1'b1;
        else if (busy_seen_q) state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= '0;
      seq_len_q <= '0;
      d_model_q <= '0;
      dt_rank_q <= '0;
      d_inner_q <= '0;
      d_final_q <= '0;
    end else if (accept) begin
      mode_q    <= csr_reg_set_i[CsrMode][ModeWidth-1:0];
      seq_len_q <= csr_reg_set_i[CsrSeqLen];
      d_model_q <= csr_reg_set_i[CsrDModel];
      dt_rank_q <= csr_reg_set_i[CsrDtRank];
      d_inner_q <= csr_reg_set_i[CsrDInner];
      d_final_q <= csr_reg_set_i[CsrDFinal];
    end
  end

  assign cfg_mode_o    = mode_q;
  assign cfg_seq_len_o = seq_len_q;
  assign cfg_d_model_o = d_model_q;
  assign cfg_dt_rank_o = dt_rank_q;
  assign cfg_d_inner_o = d_inner_q;
  assign cfg_d_final_o = d_final_q;

  snax_simbacore_sat_counter #(
    .Width    (RegDataWidth),
    .Saturate (1'b0)
  ) i_launch_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (1'b0),
    .en_i    (handshake),
    .count_o (launch_cnt)
  );

`ifdef SNAX_SIMBACORE_CSR_PERF_CNT_EN
  snax_simbacore_sat_counter #(
    .Width    (RegDataWidth),
    .Saturate (1'b1)
  ) i_cycle_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (accept),
    .en_i    (state_q != IDLE),
    .count_o (cycle_cnt)
  );
`else
  assign cycle_cnt = '0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < RegROCount; i++) csr_reg_ro_set_o[i] = '0;
    csr_reg_ro_set_o[RoBusy][0]     = (state_q != IDLE);
    csr_reg_ro_set_o[RoCycles]      = cycle_cnt;
    csr_reg_ro_set_o[RoLaunches]    = launch_cnt;
    csr_reg_ro_set_o[RoMode]        = {{(RegDataWidth-ModeWidth){1'b0}}, mode_q};
  end

endmodule

// File: tb/tb_snax_simbacore_csr_ctrl.sv
// Randomized self-checking bench for snax_simbacore_csr_ctrl against a launch-level model.
module tb_snax_simbacore_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] csr_set [7];
  logic        csr_valid = 1'b0;
  logic        csr_ready;
  logic [31:0] ro [4];
  logic        cfg_valid;
  logic        cfg_ready = 1'b0;
  logic [12:0] cfg_mode;
  logic [31:0] cfg_seq_len, cfg_d_model, cfg_dt_rank, cfg_d_inner, cfg_d_final;
  logic        core_busy = 1'b0;

  logic       cnt_clr = 1'b0, cnt_en = 1'b0;
  logic [2:0] cnt_sat, cnt_wrap;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Launch-level reference model state
  logic [31:0] new_w [6];
  logic [31:0] exp_w [6];
  logic [31:0] exp_launch;

  always #5 clk = ~clk;

  snax_simbacore_csr_ctrl #(
    .RegRWCount   (7),
    .RegROCount   (4),
    .RegDataWidth (32),
    .ModeWidth    (13)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .csr_reg_set_i       (csr_set),
    .csr_reg_set_valid_i (csr_valid),
    .csr_reg_set_ready_o (csr_ready),
    .csr_reg_ro_set_o    (ro),
    .cfg_valid_o         (cfg_valid),
    .cfg_ready_i         (cfg_ready),
    .cfg_mode_o          (cfg_mode),
    .cfg_seq_len_o       (cfg_seq_len),
    .cfg_d_model_o       (cfg_d_model),
    .cfg_dt_rank_o       (cfg_dt_rank),
    .cfg_d_inner_o       (cfg_d_inner),
    .cfg_d_final_o       (cfg_d_final),
    .core_busy_i         (core_busy)
  );

  snax_simbacore_sat_counter #(.Width(3), .Saturate(1'b1)) u_cnt_sat (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(cnt_clr), .en_i(cnt_en), .count_o(cnt_sat)
  );
  snax_simbacore_sat_counter #(.Width(3), .Saturate(1'b0)) u_cnt_wrap (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(cnt_clr), .en_i(cnt_en), .count_o(cnt_wrap)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cfg();
    check_eq("cfg_mode",    {19'b0, cfg_mode}, {19'b0, exp_w[0][12:0]});
    check_eq("cfg_seq_len", cfg_seq_len, exp_w[1]);
    check_eq("cfg_d_model", cfg_d_model, exp_w[2]);
    check_eq("cfg_dt_rank", cfg_dt_rank, exp_w[3]);
    check_eq("cfg_d_inner", cfg_d_inner, exp_w[4]);
    check_eq("cfg_d_final", cfg_d_final, exp_w[5]);
    check_eq("ro_mode",     ro[3], {19'b0, exp_w[0][12:0]});
    check_eq("ro_launches", ro[2], exp_launch);
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 6; i++) exp_w[i] = '0;
    exp_launch = '0;
    check_eq("rst_ro_busy",   ro[0], 32'd0);
    check_eq("rst_ro_cycles", ro[1], 32'd0);
    check_eq("rst_cfg_valid", {31'b0, cfg_valid}, 32'd0);
    check_eq("rst_ready",     {31'b0, csr_ready}, 32'd1);
    check_cfg();
  endtask

  task automatic spurious_request();
    csr_valid = $urandom_range(0, 1);
    for (int i = 0; i < 7; i++) csr_set[i] = $urandom;
  endtask

  // One full launch: stall = cycles cfg_ready held low, pre = busy-low cycles before busy,
  // len = busy-high cycles. Expected occupancy is (stall+1) ISSUE cycles plus, for a
  // non-zero mode, pre+len+1 RUN cycles.
  task automatic launch(input int stall, input int pre, input int len);
    logic [12:0] mode;
    int          cycles;
    check_eq("idle_ready",   {31'b0, csr_ready}, 32'd1);
    check_eq("idle_ro_busy", ro[0], 32'd0);
    for (int i = 0; i < 6; i++) csr_set[i] = new_w[i];
    csr_set[6] = $urandom;
    csr_valid  = 1'b1;
    cfg_ready  = 1'b0;
    core_busy  = 1'b0;
    step();
    csr_valid = 1'b0;
    exp_w     = new_w;
    mode      = new_w[0][12:0];
    check_eq("issue_valid",   {31'b0, cfg_valid}, 32'd1);
    check_eq("issue_ro_busy", ro[0], 32'd1);
    check_eq("issue_ready",   {31'b0, csr_ready}, 32'd0);
    check_eq("cycles_clear",  ro[1], 32'd0);
    check_cfg();
    for (int s = 0; s < stall; s++) begin
      spurious_request();
      step();
      check_eq("stall_valid", {31'b0, cfg_valid}, 32'd1);
      check_eq("stall_ready", {31'b0, csr_ready}, 32'd0);
      check_cfg();
    end
    csr_valid = 1'b0;
    cfg_ready = 1'b1;
    core_busy = (mode == '0);
    step();
    cfg_ready = 1'b0;
    exp_launch++;
    check_eq("hs_valid_drop", {31'b0, cfg_valid}, 32'd0);
    check_cfg();
    cycles = stall + 1;
    if (mode == '0) begin
      check_eq("mode0_idle", ro[0], 32'd0);
      step();
      check_eq("mode0_busy_ignored", ro[0], 32'd0);
      core_busy = 1'b0;
    end else begin
      check_eq("run_ro_busy", ro[0], 32'd1);
      for (int k = 0; k < pre; k++) begin
        spurious_request();
        core_busy = 1'b0;
        step();
        check_eq("run_pre", ro[0], 32'd1);
      end
      for (int k = 0; k < len; k++) begin
        spurious_request();
        core_busy = 1'b1;
        step();
        check_eq("run_busy", ro[0], 32'd1);
        check_eq("run_ready", {31'b0, csr_ready}, 32'd0);
      end
      csr_valid = 1'b0;
      core_busy = 1'b0;
      step();
      check_eq("run_exit", ro[0], 32'd0);
      check_cfg();
      cycles += pre + len + 1;
    end
`ifdef SNAX_SIMBACORE_CSR_PERF_CNT_EN
    check_eq("ro_cycles", ro[1], cycles);
    step();
    check_eq("ro_cycles_hold", ro[1], cycles);
`else
    check_eq("ro_cycles_off", ro[1], 32'd0);
    step();
    check_eq("ro_cycles_off_hold", ro[1], 32'd0);
`endif
    check_cfg();
  endtask

  task automatic reset_mid(input bit in_run);
    for (int i = 0; i < 6; i++) csr_set[i] = $urandom | 32'd1;
    csr_valid = 1'b1;
    step();
    csr_valid = 1'b0;
    if (in_run) begin
      cfg_ready = 1'b1;
      step();
      cfg_ready = 1'b0;
      core_busy = 1'b1;
      step();
      step();
    end
    rst_ni = 1'b0;
    #1;
    check_reset_state();
    core_busy = 1'b0;
    step();
    check_eq("rst_hold_idle", ro[0], 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    check_reset_state();
  endtask

  initial begin
    int sat_m, wrap_m;
    for (int i = 0; i < 7; i++) csr_set[i] = '0;
    #2 rst_ni = 1'b0;
    #1;
    check_reset_state();
    check_eq("rst_cnt_sat",  {29'b0, cnt_sat},  32'd0);
    check_eq("rst_cnt_wrap", {29'b0, cnt_wrap}, 32'd0);
    step();
    @(negedge clk);
    rst_ni = 1'b1;
    step();

    // Counter sub-module: narrow instances exercise saturate and wrap boundaries.
    sat_m = 0;
    wrap_m = 0;
    for (int c = 0; c < 60; c++) begin
      cnt_clr = ($urandom_range(0, 15) == 0);
      cnt_en  = ($urandom_range(0, 3) != 0);
      step();
      if (cnt_clr) begin
        sat_m = 0;
        wrap_m = 0;
      end else if (cnt_en) begin
        sat_m  = (sat_m == 7) ? 7 : sat_m + 1;
        wrap_m = (wrap_m + 1) % 8;
      end
      check_eq("cnt_sat",  {29'b0, cnt_sat},  sat_m);
      check_eq("cnt_wrap", {29'b0, cnt_wrap}, wrap_m);
    end
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    new_w[0] = 32'd5;   new_w[1] = 32'd64; new_w[2] = 32'd128;
    new_w[3] = 32'd8;   new_w[4] = 32'd256; new_w[5] = 32'd32;
    launch(0, 0, 10);
    for (int i = 0; i < 6; i++) new_w[i] = $urandom;
    new_w[0] = 32'h0000_0101;
    launch(4, 1, 3);
    new_w[0] = 32'hABCD_E000;
    launch(1, 0, 0);
    new_w[0] = 32'd7;
    launch(2, 0, 6);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 6; i++) new_w[i] = $urandom;
      if ($urandom_range(0, 3) == 0) new_w[0] = new_w[0] & 32'hFFFF_E000;
      else if (new_w[0][12:0] == '0) new_w[0][0] = 1'b1;
      launch($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(1, 8));
    end

    reset_mid(1'b1);
    reset_mid(1'b0);
    new_w[0] = 32'd3;
    launch(0, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snax_simbacore_csr_ctrl.md
SNAX_SIMBACORE_CSR_CTRL -- requirements
Module: snax_simbacore_csr_ctrl

Interface
REQ-001: Parameters, one per line: RegRWCount, default 7, CSR words incl. start word; RegROCount, default 4, read-only words; RegDataWidth, default 32, CSR word width; ModeWidth, default 13, core mode field width.
REQ-002: clk_i  input  1  single clock, all state on rising edge.
REQ-003: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004: csr_reg_set_i  input  RegRWCount x RegDataWidth  words 0-5 = mode, seqLen, dModel, dtRank, dInner, dFinal; word 6 = start (ignored).
REQ-005: csr_reg_set_valid_i / csr_reg_set_ready_o  input / output  1 each  CSR-manager launch handshake.
REQ-006: csr_reg_ro_set_o  output  RegROCount x RegDataWidth  status: [0] busy in bit 0, [1] cycle counter, [2] launch counter, [3] latched mode.
REQ-007: cfg_valid_o / cfg_ready_i  output / input  1 each  config handshake toward SimbaCore io_config.
REQ-008: cfg_mode_o  output  ModeWidth  latched mode; cfg_seq_len_o, cfg_d_model_o, cfg_dt_rank_o, cfg_d_inner_o, cfg_d_final_o  output  RegDataWidth each  latched words 1-5.
REQ-009: core_busy_i  input  1  SimbaCore io_busy_o.

Function
REQ-010: The FSM SHALL have states IDLE, ISSUE, RUN.
REQ-011: csr_reg_set_ready_o SHALL be 1 only in IDLE; an accept (valid&ready) SHALL latch words 0-5 into config registers and move to ISSUE next cycle.
REQ-012: Config outputs SHALL hold latched values, unchanged outside accept, and SHALL NOT track csr_reg_set_i.
REQ-013: In ISSUE, cfg_valid_o SHALL be 1 and held until cfg_ready_i; on cfg_valid_o&cfg_ready_i go to RUN, or to IDLE if latched mode == 0.
REQ-014: In RUN, a busy_seen flag SHALL set on any cycle core_busy_i==1; RUN SHALL exit to IDLE on the first cycle core_busy_i==0 with busy_seen==1 (set in an earlier cycle).
REQ-015: busy_seen SHALL clear on each accept.
REQ-016: csr_reg_ro_set_o[0] SHALL equal {zeros, state!=IDLE}; combinational from state.
REQ-017: Launch counter (ro[2]) SHALL increment by 1 on each cfg handshake, RegDataWidth wide, wrapping from all-ones to 0.
REQ-018: ro[3] SHALL equal latched mode zero-extended to RegDataWidth.
REQ-019: csr_reg_set_valid_i while not IDLE SHALL be ignored (no latch, no counter change).
REQ-020: Latency: accept in cycle N -> cfg_valid_o high in N+1; with cfg_ready_i=1, RUN in N+2.

Reset
REQ-021: On rst_ni low, asynchronously: state=IDLE, busy_seen=0, all config registers 0, counters 0, cfg_valid_o=0.
REQ-022: Reset asserted mid-ISSUE or mid-RUN SHALL drop cfg_valid_o immediately and re-enter IDLE with no pending launch.

Configuration
REQ-023: SNAX_SIMBACORE_CSR_PERF_CNT_EN defined: ro[1] SHALL count cycles spent in ISSUE or RUN, cleared to 0 on accept, saturating at all-ones, holding its value in IDLE.
REQ-024: Macro undefined: ro[1] SHALL be constant 0 and the counter SHALL not be instantiated.

Structure
REQ-025: Package snax_simbacore_pkg SHALL hold the FSM state enum, CSR word index constants (mode=0 ... dFinal=5, start=6) and RO index constants.
REQ-026: One sub-module, snax_simbacore_sat_counter (parameterised width, clear, enable, saturate/wrap select), SHALL implement ro[1] and ro[2].

Verification
REQ-027: Reset, then accept words {5,64,128,8,256,32}, cfg_ready_i=1, busy high 10 cycles -> cfg outputs match, ro[2]=1, ro[0] bit0 high ISSUE..RUN, IDLE after busy falls.
REQ-028: cfg_ready_i held low 4 cycles -> cfg_valid_o stays 1, outputs stable, single handshake, ro[2]=1.
REQ-029: Mode 0 launch -> ISSUE to IDLE after handshake, busy ignored, ro[2] increments.
REQ-030: Second csr valid during RUN -> ready 0, config unchanged, ro[2] unchanged.
REQ-031: Perf macro on, 3 ISSUE + 7 RUN cycles -> ro[1]=10, held in IDLE, cleared on next accept; macro off -> ro[1]=0.
REQ-032: rst_ni low mid-RUN -> state IDLE, cfg outputs 0, ro all 0 that cycle.
